// File: rtl/io_input_responder.sv
// io_input_responder: responder for the CPU IN instruction.
// Collects up to MAX_DIGITS decimal digits from the board switches and
// confirm button, echoes them, and returns the binary value with an ack.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   in_req            CPU IN pending (level, held until in_ack)
//   switch_data[3:0]  board data switches (asynchronous)
//   confirm_btn       board push-button (asynchronous, active-high)
//   in_ack            one-cycle pulse, in_data valid
//   in_data[31:0]     zero-extended entered value, held until next ack
//   digit_uni/dez/cen echo of entered digits
//   waiting           high while collecting digits
//   digit_err         one-cycle pulse on a rejected switch value
module io_input_responder #(
    parameter int          MAX_DIGITS      = 3,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [3:0]  ENTER_CODE      = 4'hA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_req,
    input  logic [3:0]  switch_data,
    input  logic        confirm_btn,
    output logic        in_ack,
    output logic [31:0] in_data,
    output logic [3:0]  digit_uni,
    output logic [3:0]  digit_dez,
    output logic [3:0]  digit_cen,
    output logic        waiting,
    output logic        digit_err
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]     CNT_LAST = 2'(MAX_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ACK,
        RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     sw_s1_q, sw_s1_d;
    logic [3:0]     sw_s2_q, sw_s2_d;
    logic           btn_s1_q, btn_s1_d;
    logic           btn_s2_q, btn_s2_d;
    logic           filt_q, filt_d;
    logic           filt_prev_q, filt_prev_d;
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic [9:0]     acc_q, acc_d;
    logic [1:0]     count_q, count_d;
    logic [3:0]     uni_q, uni_d;
    logic [3:0]     dez_q, dez_d;
    logic [3:0]     cen_q, cen_d;
    logic [9:0]     in_data_q, in_data_d;
    logic           in_ack_q, in_ack_d;
    logic           waiting_q, waiting_d;
    logic           digit_err_q, digit_err_d;

    logic           press;
    logic           is_digit;
    logic [9:0]     acc_next;

    always_comb begin
        state_d     = state_q;
        sw_s1_d     = switch_data;
        sw_s2_d     = sw_s1_q;
        btn_s1_d    = confirm_btn;
        btn_s2_d    = btn_s1_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        db_cnt_d    = db_cnt_q;
        acc_d       = acc_q;
        count_d     = count_q;
        uni_d       = uni_q;
        dez_d       = dez_q;
        cen_d       = cen_q;
        in_data_d   = in_data_q;
        in_ack_d    = 1'b0;
        digit_err_d = 1'b0;

        // Filtered level flips only after DEBOUNCE_CYCLES samples in a row
        // that disagree with it; any agreeing sample restarts the count.
        if (btn_s2_q == filt_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            filt_d   = btn_s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        press    = filt_q & ~filt_prev_q;
        is_digit = (sw_s2_q <= 4'd9);
        // acc*10 + d; 999 max so 10 bits never overflow
        acc_next = (acc_q << 3) + (acc_q << 1) + {6'b0, sw_s2_q};

        unique case (state_q)
            IDLE: begin
                if (in_req) begin
                    state_d = COLLECT;
                    acc_d   = '0;
                    count_d = '0;
                    uni_d   = '0;
                    dez_d   = '0;
                    cen_d   = '0;
                end
            end
            COLLECT: begin
                // Abort wins over a press in the same cycle
                if (!in_req) begin
                    state_d = IDLE;
                end else if (press) begin
                    if (is_digit) begin
                        acc_d   = acc_next;
                        cen_d   = dez_q;
                        dez_d   = uni_q;
                        uni_d   = sw_s2_q;
                        count_d = count_q + 2'd1;
                        if (count_q == CNT_LAST) begin
                            state_d   = ACK;
                            in_ack_d  = 1'b1;
                            in_data_d = acc_next;
                        end
                    end else if (sw_s2_q == ENTER_CODE && count_q != 2'd0) begin
                        state_d   = ACK;
                        in_ack_d  = 1'b1;
                        in_data_d = acc_q;
                    end else begin
                        digit_err_d = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the CPU to drop the request so it cannot retrigger
                if (!in_req) begin
                    state_d = IDLE;
                end
            end
        endcase

        waiting_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            db_cnt_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            uni_q       <= '0;
            dez_q       <= '0;
            cen_q       <= '0;
            in_data_q   <= '0;
            in_ack_q    <= 1'b0;
            waiting_q   <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            db_cnt_q    <= db_cnt_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            uni_q       <= uni_d;
            dez_q       <= dez_d;
            cen_q       <= cen_d;
            in_data_q   <= in_data_d;
            in_ack_q    <= in_ack_d;
            waiting_q   <= waiting_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign in_ack    = in_ack_q;
    assign in_data   = {22'b0, in_data_q};
    assign digit_uni = uni_q;
    assign digit_dez = dez_q;
    assign digit_cen = cen_q;
    assign waiting   = waiting_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder: directed bench for io_input_responder.
// Hand-computed expectations checked with immediate assertions.
module tb_io_input_responder;

    logic        clk;
    logic        reset;
    logic        in_req;
    logic [3:0]  switch_data;
    logic        confirm_btn;
    logic        in_ack;
    logic [31:0] in_data;
    logic [3:0]  digit_uni;
    logic [3:0]  digit_dez;
    logic [3:0]  digit_cen;
    logic        waiting;
    logic        digit_err;

    int vectors;
    int miscompares;
    int ack_cnt;
    int err_cnt;
    int a0;
    int e0;

    io_input_responder dut (
        .clk        (clk),
        .reset      (reset),
        .in_req     (in_req),
        .switch_data(switch_data),
        .confirm_btn(confirm_btn),
        .in_ack     (in_ack),
        .in_data    (in_data),
        .digit_uni  (digit_uni),
        .digit_dez  (digit_dez),
        .digit_cen  (digit_cen),
        .waiting    (waiting),
        .digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ack_cnt = 0;
        err_cnt = 0;
    end

    always @(negedge clk) begin
        if (in_ack === 1'b1) ack_cnt++;
        if (digit_err === 1'b1) err_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        switch_data = v;
        confirm_btn = 1'b1;
        step(hold);
        confirm_btn = 1'b0;
        step(8);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_req      = 1'b0;
        switch_data = 4'd0;
        confirm_btn = 1'b0;
        step(2);
        chk("rst_ack", in_ack, 0);
        chk("rst_data", in_data, 0);
        chk("rst_uni", digit_uni, 0);
        chk("rst_dez", digit_dez, 0);
        chk("rst_cen", digit_cen, 0);
        chk("rst_wait", waiting, 0);
        chk("rst_err", digit_err, 0);
        reset = 1'b0;
        step(2);

        // 1, 2, 3 -> 123, with exact ack latency on the final digit
        a0 = ack_cnt;
        in_req = 1'b1;
        step(1);
        chk("t1_wait_rise", waiting, 1);
        press(4'd1, 8);
        chk("t1_uni1", digit_uni, 1);
        press(4'd2, 8);
        chk("t1_uni2", digit_uni, 2);
        chk("t1_dez2", digit_dez, 1);
        switch_data = 4'd3;
        confirm_btn = 1'b1;
        step(6);
        chk("t1_ack_early", in_ack, 0);
        chk("t1_wait_pre", waiting, 1);
        step(1);
        chk("t1_ack", in_ack, 1);
        chk("t1_data", in_data, 123);
        chk("t1_wait_fall", waiting, 0);
        chk("t1_cen", digit_cen, 1);
        chk("t1_dez", digit_dez, 2);
        chk("t1_uni", digit_uni, 3);
        step(1);
        chk("t1_ack_pulse", in_ack, 0);
        confirm_btn = 1'b0;
        step(8);
        chk("t1_ack_count", ack_cnt - a0, 1);
        in_req = 1'b0;
        step(2);

        // 4 then enter -> 4
        a0 = ack_cnt;
        in_req = 1'b1;
        step(1);
        press(4'd4, 8);
        press(4'hA, 8);
        chk("t2_ack_count", ack_cnt - a0, 1);
        chk("t2_data", in_data, 4);
        chk("t2_cen", digit_cen, 0);
        chk("t2_dez", digit_dez, 0);
        chk("t2_uni", digit_uni, 4);
        in_req = 1'b0;
        step(2);

        // Enter with no digits -> error pulse, no ack
        a0 = ack_cnt;
        e0 = err_cnt;
        in_req = 1'b1;
        step(1);
        switch_data = 4'hA;
        confirm_btn = 1'b1;
        step(7);
        chk("t3_err_hi", digit_err, 1);
        step(1);
        chk("t3_err_pulse", digit_err, 0);
        confirm_btn = 1'b0;
        step(8);
        chk("t3_err_count", err_cnt - e0, 1);
        chk("t3_no_ack", ack_cnt - a0, 0);
        chk("t3_wait", waiting, 1);

        // Invalid 0xC then 9, 9, 9 -> 999
        e0 = err_cnt;
        press(4'hC, 8);
        chk("t4_err_count", err_cnt - e0, 1);
        chk("t4_uni", digit_uni, 0);
        press(4'd9, 8);
        press(4'd9, 8);
        chk("t4_no_ack_yet", ack_cnt - a0, 0);
        press(4'd9, 8);
        chk("t4_ack_count", ack_cnt - a0, 1);
        chk("t4_data", in_data, 999);
        in_req = 1'b0;
        step(2);

        // Bounce 1-0-1 at 2-cycle spacing, then stable: one digit
        a0 = ack_cnt;
        e0 = err_cnt;
        in_req = 1'b1;
        step(1);
        switch_data = 4'd5;
        confirm_btn = 1'b1;
        step(2);
        confirm_btn = 1'b0;
        step(2);
        confirm_btn = 1'b1;
        step(6);
        confirm_btn = 1'b0;
        step(8);
        chk("t5_uni", digit_uni, 5);
        chk("t5_dez", digit_dez, 0);
        chk("t5_no_err", err_cnt - e0, 0);
        press(4'hA, 8);
        chk("t5_data", in_data, 5);
        chk("t5_ack_count", ack_cnt - a0, 1);
        in_req = 1'b0;
        step(2);

        // Abort after two digits
        a0 = ack_cnt;
        in_req = 1'b1;
        step(1);
        press(4'd8, 8);
        press(4'd6, 8);
        in_req = 1'b0;
        step(1);
        chk("t6_wait_abort", waiting, 0);
        step(3);
        chk("t6_no_ack", ack_cnt - a0, 0);
        chk("t6_data_kept", in_data, 5);
        in_req = 1'b1;
        step(1);
        chk("t6_uni_clr", digit_uni, 0);
        press(4'd7, 8);
        press(4'hA, 8);
        chk("t6_data", in_data, 7);
        chk("t6_ack_count", ack_cnt - a0, 1);

        // Request still held with button pressed: no retrigger
        a0 = ack_cnt;
        e0 = err_cnt;
        switch_data = 4'd2;
        confirm_btn = 1'b1;
        step(10);
        chk("t7_no_ack", ack_cnt - a0, 0);
        chk("t7_no_err", err_cnt - e0, 0);
        chk("t7_wait", waiting, 0);
        confirm_btn = 1'b0;
        step(8);
        in_req = 1'b0;
        step(2);
        in_req = 1'b1;
        step(1);
        chk("t7_rearm", waiting, 1);

        // Async reset in the middle of an entry
        press(4'd3, 8);
        chk("t8_uni_pre", digit_uni, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t8_rst_uni", digit_uni, 0);
        chk("t8_rst_wait", waiting, 0);
        chk("t8_rst_data", in_data, 0);
        chk("t8_rst_ack", in_ack, 0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("t8_restart", waiting, 1);
        a0 = ack_cnt;
        press(4'd6, 8);
        press(4'hA, 8);
        chk("t8_data", in_data, 6);
        chk("t8_ack_count", ack_cnt - a0, 1);
        in_req = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
